mux_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing one dual 4-to-1 mux path (74153-style: 2-bit sel, active-low enable per section) between 4 requesters.
- Drives the mux `sel` and `notIE` so the mux is disabled (outputs low) while the select lines change.
- Holds the enable off for a programmable settle time, covering the mux propagation delay, before granting.
- Sits beside the shared mux in the datapath; requesters see a one-hot grant.

---
 rtl/mux_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mux_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter
// Round-robin arbiter for one shared dual 4-to-1 mux path (74153 pair).
// Four requesters share the mux. The arbiter drives sel and the active-low
// enables (notIE), and gives each requester a one-hot grant.
// Before a grant is issued, the mux is held disabled with sel stable for
// SETTLE_CYCLES clocks. This covers the mux propagation delay.
// Optional build macro: MUX_ARB_TIMEOUT_EN. When defined, a tenure is
// revoked after MAX_HOLD clocks if another requester is waiting.

module mux_bus_arbiter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_HOLD      = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic [1:0] notIE,
   output logic       busy
);

   // Reject parameter values that the counters cannot represent.
   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("mux_bus_arbiter: SETTLE_CYCLES must be 1..15");
      end
      if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
         $error("mux_bus_arbiter: MAX_HOLD must be 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GRANT  = 2'd2
   } state_t;

   localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   // Expand a 2-bit requester index into its one-hot grant vector.
   function automatic logic [3:0] f_onehot(input logic [1:0] idx);
      f_onehot = 4'b0001 << idx;
   endfunction

   // Pick the first set request, scanning last+1, last+2, last+3, last+4.
   // The loop runs from the farthest slot to the nearest.
   // Each later hit overwrites the earlier one, so the nearest slot wins.
   function automatic logic [1:0] f_rr_pick(input logic [1:0] last,
                                            input logic [3:0] rq);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (rq[idx]) begin
            pick = idx;
         end
      end
      f_rr_pick = pick;
   endfunction

   state_t     r_state;
   logic [3:0] r_grant;
   logic [1:0] r_sel;
   logic [1:0] r_notie;
   logic [1:0] r_last;
   logic [3:0] r_cnt;

   logic [1:0] w_winner;
   logic       w_req_sel;

   assign w_winner  = f_rr_pick(r_last, req);
   assign w_req_sel = req[r_sel];

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

   logic [7:0] r_hold;
   logic       w_others;

   // Another requester is waiting: some req bit other than the current owner is set.
   assign w_others = |(req & ~f_onehot(r_sel));
`endif

   // Arbitration FSM: selection, settle countdown, grant tenure and release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= 4'b0000;
         r_sel   <= 2'b00;
         r_notie <= 2'b11;
         r_last  <= 2'd3;
         r_cnt   <= 4'd0;
`ifdef MUX_ARB_TIMEOUT_EN
         r_hold  <= 8'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_grant <= 4'b0000;
               r_notie <= 2'b11;
               if (|req) begin
                  r_sel   <= w_winner;
                  r_cnt   <= LP_SETTLE_LOAD;
                  r_state <= ST_SETTLE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_SETTLE: begin
               if (!w_req_sel) begin
                  // Requester withdrew before its grant.
                  // Abort without touching the round-robin pointer.
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= ST_GRANT;
                  r_notie <= 2'b00;
                  r_grant <= f_onehot(r_sel);
                  r_last  <= r_sel;
`ifdef MUX_ARB_TIMEOUT_EN
                  r_hold  <= 8'd0;
`endif
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_GRANT: begin
               if (!w_req_sel) begin
                  r_grant <= 4'b0000;
                  r_notie <= 2'b11;
                  r_state <= ST_IDLE;
`ifdef MUX_ARB_TIMEOUT_EN
               end else if ((r_hold == LP_MAX_HOLD) && w_others) begin
                  // Tenure expired with a waiter: revoke.
                  // The owner is already lastGrant, so it gets lowest priority next.
                  r_grant <= 4'b0000;
                  r_notie <= 2'b11;
                  r_state <= ST_IDLE;
               end else begin
                  if (r_hold != LP_MAX_HOLD) begin
                     r_hold <= r_hold + 8'd1;
                  end else begin
                     r_hold <= r_hold;
                  end
               end
`else
               end else begin
                  r_state <= ST_GRANT;
               end
`endif
            end

            default: begin
               // Unreachable encoding: return to a safe, disabled idle.
               r_state <= ST_IDLE;
               r_grant <= 4'b0000;
               r_notie <= 2'b11;
            end
         endcase
      end
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign notIE = r_notie;
   assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Self-checking bench for mux_bus_arbiter.
// - Table vectors cover single-request latency and abort.
// - Hand-written sequences cover async reset, round-robin and tenure limits.
// - Random request traffic is checked against a time-stamp reference model.

module tb_mux_bus_arbiter;

   localparam int SETTLE = 2;
   localparam int HOLD   = 4;

   logic       clock;
   logic       reset;
   logic [3:0] req_v;
   logic [3:0] grant;
   logic [1:0] sel;
   logic [1:0] notIE;
   logic       busy;

   int checks = 0;
   int errors = 0;

   mux_bus_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_HOLD(HOLD)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req_v),
      .grant (grant),
      .sel   (sel),
      .notIE (notIE),
      .busy  (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state.
   // Phase: 0 idle, 1 waiting for settle, 2 granted.
   // Edge time stamps replace explicit counters.
   int m_phase, m_sel, m_last, m_t0, m_tg, cyc;
   logic [1:0] prev_sel;
   logic [1:0] prev_notie;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_phase = 0; m_sel = 0; m_last = 3; m_t0 = 0; m_tg = 0;
   endtask

   task automatic m_edge(input logic [3:0] rq);
      int w;
      logic [3:0] oh;
      cyc++;
      w = 0;
      if (m_phase == 0) begin
         if (rq != 4'b0000) begin
            for (int j = 4; j >= 1; j--) if (rq[(m_last + j) % 4]) w = (m_last + j) % 4;
            m_sel = w; m_t0 = cyc; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!rq[m_sel]) m_phase = 0;
         else if (cyc == m_t0 + SETTLE) begin m_phase = 2; m_last = m_sel; m_tg = cyc; end
      end else begin
         oh = 4'b0001 << m_sel;
         if (!rq[m_sel]) m_phase = 0;
`ifdef MUX_ARB_TIMEOUT_EN
         else if ((cyc - m_tg) > HOLD && (rq & ~oh) != 4'b0000) m_phase = 0;
`endif
      end
   endtask

   task automatic check_model();
      logic [3:0] eg;
      eg = (m_phase == 2) ? (4'b0001 << m_sel) : 4'b0000;
      chk("grant", 32'(grant), 32'(eg));
      chk("notIE", 32'(notIE), (m_phase == 2) ? 32'd0 : 32'd3);
      chk("sel", 32'(sel), 32'(m_sel));
      chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
      chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
      chk("inv_grant_ie", 32'(grant != 4'b0000), 32'(notIE == 2'b00));
      chk("inv_ie_pair", 32'(notIE[0]), 32'(notIE[1]));
      if (prev_notie == 2'b00 && notIE == 2'b00) chk("inv_sel_stable", 32'(sel), 32'(prev_sel));
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) m_edge(req_v);
      #1;
      check_model();
      prev_sel = sel;
      prev_notie = notIE;
   endtask

   // Mid-cycle asynchronous reset pulse.
   // Outputs are checked before any clock edge occurs.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      m_reset();
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_notIE", 32'(notIE), 32'd3);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      prev_notie = 2'b11;
      prev_sel = sel;
      #1;
      reset = 1'b0;
   endtask

   typedef struct packed {
      logic       rst_before;
      logic [3:0] rq;
      logic [3:0] g;
      logic [1:0] s;
      logic [1:0] ie;
      logic       b;
   } vec_t;

   vec_t tbl [15];
   int order [$];
   int n, ten;
   logic [3:0] prev_g;

   initial begin
      reset = 1'b1; req_v = 4'b0000; cyc = 0;
      prev_notie = 2'b11; prev_sel = 2'b00;
      m_reset();

      // Vectors 0-5: single request from requester 2 with SETTLE=2, then release.
      // Vectors 6-14: abort during settle, then the 0011 order after reset.
      tbl[0]  = '{1'b0, 4'b0100, 4'b0000, 2'd2, 2'b11, 1'b1};
      tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 2'd2, 2'b11, 1'b1};
      tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 2'b00, 1'b1};
      tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 2'b00, 1'b1};
      tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 2'b11, 1'b0};
      tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 2'b11, 1'b0};
      tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 2'd1, 2'b11, 1'b1};
      tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 2'b11, 1'b0};
      tbl[8]  = '{1'b0, 4'b0011, 4'b0000, 2'd0, 2'b11, 1'b1};
      tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 2'd0, 2'b11, 1'b1};
      tbl[10] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 2'b00, 1'b1};
      tbl[11] = '{1'b0, 4'b0010, 4'b0000, 2'd0, 2'b11, 1'b0};
      tbl[12] = '{1'b0, 4'b0010, 4'b0000, 2'd1, 2'b11, 1'b1};
      tbl[13] = '{1'b0, 4'b0010, 4'b0000, 2'd1, 2'b11, 1'b1};
      tbl[14] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 2'b00, 1'b1};

      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst_before) do_reset();
         req_v = tbl[i].rq;
         tick();
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].s));
         chk($sformatf("vec%0d_notIE", i), 32'(notIE), 32'(tbl[i].ie));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      end

      // Asynchronous reset in the middle of a grant tenure.
      do_reset();
      req_v = 4'b1000;
      for (int i = 0; i < 3; i++) tick();
      chk("pre_rst_grant", 32'(grant), 32'h8);
      do_reset();
      req_v = 4'b0000;
      tick();

      // Round-robin with all four requesting.
      // Each owner drops req for one cycle after its first granted cycle.
      do_reset();
      req_v = 4'hf;
      prev_g = 4'b0000;
      n = 0;
      while (order.size() < 5 && n < 100) begin
         tick();
         n++;
         if (grant != 4'b0000 && prev_g == 4'b0000) order.push_back(int'(grant));
         prev_g = grant;
         req_v = (grant != 4'b0000) ? (4'hf & ~grant) : 4'hf;
      end
      chk("rr_count", 32'(order.size()), 32'd5);
      if (order.size() == 5) begin
         chk("rr_0", 32'(order[0]), 32'h1);
         chk("rr_1", 32'(order[1]), 32'h2);
         chk("rr_2", 32'(order[2]), 32'h4);
         chk("rr_3", 32'(order[3]), 32'h8);
         chk("rr_4", 32'(order[4]), 32'h1);
      end
      req_v = 4'b0000;
      tick(); tick();

      // Tenure limit: requester 0 holds the grant while requester 2 waits.
      do_reset();
      req_v = 4'b0001;
      for (int i = 0; i < 3; i++) tick();
      chk("hold_start", 32'(grant), 32'h1);
      req_v = 4'b0101;
`ifdef MUX_ARB_TIMEOUT_EN
      ten = 1;
      n = 0;
      while (grant == 4'b0001 && n < 20) begin tick(); n++; if (grant == 4'b0001) ten++; end
      chk("timeout_tenure", 32'(ten), 32'(HOLD + 1));
      n = 0;
      while (grant != 4'b0100 && n < SETTLE + 4) begin tick(); n++; end
      chk("timeout_next_grant", 32'(grant), 32'h4);
      req_v = 4'b0000;
      tick(); tick();
      do_reset();
      req_v = 4'b0001;
      for (int i = 0; i < 3; i++) tick();
      ten = 0;
      for (int i = 0; i < 50; i++) begin tick(); if (grant != 4'b0001) ten++; end
      chk("alone_no_revoke", 32'(ten), 32'd0);
`else
      ten = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (grant != 4'b0001) ten++; end
      chk("no_timeout_hold", 32'(ten), 32'd0);
`endif
      req_v = 4'b0000;
      tick(); tick();

      // Random request traffic with occasional async resets, checked by the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req_v[b] = ~req_v[b];
         if ($urandom_range(0, 499) == 0) do_reset();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
